// File: rtl/spi_target_if.sv
// SPI pin bundle between a controller and the spi_target register block.
// The controller drives clock, select and data in; the target drives data out.
interface spi_target_if;

   logic i_sck;
   logic i_cs_n;
   logic i_sdi;
   logic o_sdo;
   logic o_sdo_en;

   modport master (
      output i_sck,
      output i_cs_n,
      output i_sdi,
      input  o_sdo,
      input  o_sdo_en
   );

   modport slave (
      input  i_sck,
      input  i_cs_n,
      input  i_sdi,
      output o_sdo,
      output o_sdo_en
   );

endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target exposing three 8-bit registers plus a status byte.
// All SPI pins are oversampled in the i_clk domain; edges come from synced samples.
module spi_target #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   spi_target_if.slave spi,
   input  logic [7:0]  i_status,
   output logic [23:0] o_regs,
   output logic        o_wr_strobe,
   output logic [1:0]  o_wr_addr,
   output logic        o_busy
);

   // A chain shorter than two flops is not a synchronizer; clamp it.
   localparam int SN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      SKIP
   } state_t;

   state_t state;
   state_t state_nx;

   logic [SN-1:0] sck_sync;
   logic [SN-1:0] cs_sync;
   logic [SN-1:0] sdi_sync;

   logic sck_d;
   logic cs_d;
   logic sck_rise;
   logic sck_fall;
   logic cs_rise;
   logic cs_fall;
   logic sdi_b;

   logic [2:0] bit_cnt;
   logic [6:0] rx_sr;
   logic [7:0] tx_sr;
   logic       load_pend;
   logic       wr_mode;
   logic [1:0] ptr;

   logic [7:0] reg0;
   logic [7:0] reg1;
   logic [7:0] reg2;

   logic [7:0] byte_in;
   logic       byte_done;
   logic       cmd_ok;
   logic [7:0] rd_byte;

   // Synchronize the pins and register one-cycle edge pulses aligned with sdi.
   // The select chain resets to "asserted" so that a reset taken while the
   // controller holds CS low never looks like a fresh CS falling edge.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sck_sync <= '0;
         cs_sync  <= '0;
         sdi_sync <= '0;
         sck_d    <= 1'b0;
         cs_d     <= 1'b0;
         sck_rise <= 1'b0;
         sck_fall <= 1'b0;
         cs_rise  <= 1'b0;
         cs_fall  <= 1'b0;
         sdi_b    <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SN-2:0], spi.i_sck};
         cs_sync  <= {cs_sync[SN-2:0], spi.i_cs_n};
         sdi_sync <= {sdi_sync[SN-2:0], spi.i_sdi};
         sck_d    <= sck_sync[SN-1];
         cs_d     <= cs_sync[SN-1];
         sck_rise <= sck_sync[SN-1] & ~sck_d;
         sck_fall <= ~sck_sync[SN-1] & sck_d;
         cs_rise  <= cs_sync[SN-1] & ~cs_d;
         cs_fall  <= ~cs_sync[SN-1] & cs_d;
         sdi_b    <= sdi_sync[SN-1];
      end
   end

   assign byte_in   = {rx_sr, sdi_b};
   assign byte_done = sck_rise && (bit_cnt == 3'd7);
   assign cmd_ok    = (byte_in[6:2] == 5'd0);

   // Read mux: address 3 returns the live status input at load time.
   always_comb begin
      rd_byte = i_status;
      unique case (ptr)
         2'd0: rd_byte = reg0;
         2'd1: rd_byte = reg1;
         2'd2: rd_byte = reg2;
         2'd3: rd_byte = i_status;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; a CS rise wins last so it aborts from any state.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (cs_fall) begin
               state_nx = CMD;
            end
         end
         CMD: begin
            if (byte_done) begin
               state_nx = cmd_ok ? DATA : SKIP;
            end
         end
         DATA: begin
            state_nx = DATA;
         end
         SKIP: begin
            state_nx = SKIP;
         end
      endcase
      if ((state != IDLE) && cs_rise) begin
         state_nx = IDLE;
      end
   end

   // Shift registers, pointer and register file; byte work precedes abort.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         bit_cnt     <= 3'd0;
         rx_sr       <= 7'd0;
         tx_sr       <= 8'd0;
         load_pend   <= 1'b0;
         wr_mode     <= 1'b0;
         ptr         <= 2'd0;
         reg0        <= 8'd0;
         reg1        <= 8'd0;
         reg2        <= 8'd0;
         o_wr_strobe <= 1'b0;
         o_wr_addr   <= 2'd0;
      end else begin
         o_wr_strobe <= 1'b0;
         if (state == IDLE) begin
            if (cs_fall) begin
               bit_cnt   <= 3'd0;
               rx_sr     <= 7'd0;
               tx_sr     <= 8'd0;
               load_pend <= 1'b0;
            end
         end else begin
            if (sck_rise && (state != SKIP)) begin
               rx_sr   <= byte_in[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (state == CMD) begin
                     if (cmd_ok) begin
                        wr_mode   <= byte_in[7];
                        ptr       <= byte_in[1:0];
                        load_pend <= ~byte_in[7];
                     end
                  end else begin
                     if (wr_mode && (ptr != 2'd3)) begin
                        unique case (ptr)
                           2'd0: reg0 <= byte_in;
                           2'd1: reg1 <= byte_in;
                           2'd2: reg2 <= byte_in;
                           2'd3: reg2 <= reg2;
                        endcase
                        o_wr_strobe <= 1'b1;
                        o_wr_addr   <= ptr;
                     end
                     ptr       <= ptr + 2'd1;
                     load_pend <= ~wr_mode;
                  end
               end
            end
            if (sck_fall && (state != SKIP)) begin
               if (load_pend) begin
                  tx_sr     <= rd_byte;
                  load_pend <= 1'b0;
               end else begin
                  tx_sr <= {tx_sr[6:0], 1'b0};
               end
            end
            if (cs_rise) begin
               bit_cnt   <= 3'd0;
               load_pend <= 1'b0;
               tx_sr     <= 8'd0;
            end
         end
      end
   end

   assign spi.o_sdo    = tx_sr[7];
   assign spi.o_sdo_en = (state != IDLE);
   assign o_busy       = (state != IDLE);
   assign o_regs       = {reg2, reg1, reg0};

endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target against a byte-level register model.
// The controller side is bit-banged at i_clk/16.
module tb_spi_target;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  status;
   logic [23:0] regs;
   logic        wr_strobe;
   logic [1:0]  wr_addr;
   logic        busy;

   always #5 clk = ~clk;

   spi_target_if spi ();

   spi_target #(.SYNC_STAGES(SYNC)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .spi         (spi),
      .i_status    (status),
      .o_regs      (regs),
      .o_wr_strobe (wr_strobe),
      .o_wr_addr   (wr_addr),
      .o_busy      (busy)
   );

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] m_reg [4];
   logic [7:0] td [9];
   logic [7:0] rd [8];
   int exp_q [$];
   int got_q [$];
   int lat_q [$];
   int cyc = 0;
   int sck_up_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) begin
         got_q.push_back(int'(wr_addr));
         lat_q.push_back(cyc - sck_up_cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits,
                       output logic [7:0] rx);
      rx = 8'd0;
      for (int i = 0; i < nbits; i++) begin
         spi.i_sdi = tx[7-i];
         tick(8);
         rx[7-i] = spi.o_sdo;
         spi.i_sck = 1'b1;
         sck_up_cyc = cyc;
         tick(8);
         spi.i_sck = 1'b0;
      end
   endtask

   task automatic cs_begin();
      spi.i_cs_n = 1'b0;
      tick(8);
   endtask

   task automatic cs_end();
      tick(4);
      spi.i_cs_n = 1'b1;
      tick(12);
   endtask

   function automatic logic [23:0] model_regs();
      return {m_reg[2], m_reg[1], m_reg[0]};
   endfunction

   task automatic run_txn(input logic [7:0] cmd, input int nb,
                          input int abort_bits);
      logic [7:0] r;
      logic [7:0] e;
      bit wr;
      bit ok;
      int p;
      exp_q.delete();
      got_q.delete();
      lat_q.delete();
      cs_begin();
      xfer(cmd, 8, r);
      check("cmd_sdo", r, 0);
      check("sdo_en_act", spi.o_sdo_en, 1);
      ok = (cmd[6:2] == 5'd0);
      wr = cmd[7];
      p = int'(cmd[1:0]);
      for (int b = 0; b < nb; b++) begin
         xfer(td[b], 8, r);
         rd[b] = r;
         if (!ok) begin
            check("skip_sdo", r, 0);
         end else if (!wr) begin
            e = (p == 3) ? status : m_reg[p];
            check($sformatf("rd%0d", b), r, e);
         end else if (p != 3) begin
            m_reg[p] = td[b];
            exp_q.push_back(p);
         end
         p = (p + 1) % 4;
      end
      if (abort_bits > 0) xfer(td[nb], abort_bits, r);
      cs_end();
      check("busy_end", busy, 0);
      check("sdo_en_end", spi.o_sdo_en, 0);
      check("n_strobe", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check("strobe_addr", got_q[i], exp_q[i]);
      check("regs", regs, model_regs());
   endtask

   initial begin
      #900_000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] r;
      logic [7:0] cmd;
      int nb;
      int ab;
      rst = 1'b1;
      status = 8'd0;
      spi.i_sck = 1'b0;
      spi.i_cs_n = 1'b1;
      spi.i_sdi = 1'b0;
      for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
      tick(3);
      check("rst_regs", regs, 0);
      check("rst_sdo", spi.o_sdo, 0);
      check("rst_sdo_en", spi.o_sdo_en, 0);
      check("rst_strobe", wr_strobe, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      tick(10);
      check("idle_busy", busy, 0);

      // Write burst starting at address 1, wrapping into discarded address 3.
      td[0] = 8'hA5; td[1] = 8'h5A; td[2] = 8'h3C;
      run_txn(8'h81, 3, 0);
      check("burst_reg1", regs[15:8], 8'hA5);
      check("burst_reg2", regs[23:16], 8'h5A);
      check("burst_reg0", regs[7:0], 8'h00);
      check("burst_nstb", got_q.size(), 2);
      foreach (lat_q[i]) check("strobe_lat", lat_q[i], SYNC + 2);

      // Read wrap from address 2.
      td[0] = 8'h11; td[1] = 8'h22; td[2] = 8'h33;
      run_txn(8'h80, 3, 0);
      status = 8'hC4;
      for (int i = 0; i < 4; i++) td[i] = 8'hFF;
      run_txn(8'h02, 4, 0);
      check("wrap_b0", rd[0], 8'h33);
      check("wrap_b1", rd[1], 8'hC4);
      check("wrap_b2", rd[2], 8'h11);
      check("wrap_b3", rd[3], 8'h22);

      // Abort a write after five bits.
      got_q.delete();
      cs_begin();
      xfer(8'h80, 8, r);
      xfer(8'hFF, 5, r);
      check("abort_busy_pre", busy, 1);
      spi.i_cs_n = 1'b1;
      tick(SYNC + 2);
      check("abort_busy", busy, 0);
      tick(10);
      check("abort_nstb", got_q.size(), 0);
      check("abort_reg0", regs[7:0], 8'h11);

      // Reserved command bits.
      td[0] = 8'hEE;
      run_txn(8'h84, 1, 0);
      check("rsv_regs", regs, 24'h332211);

      // Reset during the second data bit of a write.
      got_q.delete();
      cs_begin();
      xfer(8'h80, 8, r);
      xfer(8'h77, 1, r);
      spi.i_sdi = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
      check("rst_mid_regs", regs, 0);
      check("rst_mid_busy", busy, 0);
      spi.i_sck = 1'b1;
      tick(8);
      spi.i_sck = 1'b0;
      xfer(8'hDC, 6, r);
      check("rst_mid_ign", busy, 0);
      cs_end();
      check("rst_mid_nstb", got_q.size(), 0);
      check("rst_mid_regs2", regs, 0);
      td[0] = 8'h12;
      run_txn(8'h80, 1, 0);
      check("rst_next_reg0", regs[7:0], 8'h12);

      // SCK activity with CS high.
      got_q.delete();
      for (int i = 0; i < 20; i++) begin
         spi.i_sdi = 1'($urandom);
         spi.i_sck = ~spi.i_sck;
         tick(6);
         check("cs_hi_busy", busy, 0);
         check("cs_hi_en", spi.o_sdo_en, 0);
      end
      spi.i_sck = 1'b0;
      tick(6);
      check("cs_hi_nstb", got_q.size(), 0);
      check("cs_hi_regs", regs, model_regs());

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         status = 8'($urandom);
         cmd[7] = 1'($urandom);
         cmd[1:0] = 2'($urandom);
         cmd[6:2] = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31))
                                                : 5'd0;
         nb = $urandom_range(0, 5);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < 9; i++) td[i] = 8'($urandom);
         run_txn(cmd, nb, ab);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
